pulpissimo_reset_sequencer: RTL
===============================

// Module: pulpissimo_reset_sequencer
//
// PURPOSE
// - Generates the sequenced SoC reset and JTAG TRST for the PULPissimo FPGA top from the board reset button, the clock-lock flag and a software reset request.
// - Sits between the board pads and the pulpissimo instance in the xilinx_pulpissimo top, in the ref_clk domain.
// - Holds the SoC in reset until the clock is stable, releases SoC then JTAG in a fixed order, and serves warm resets that keep JTAG alive.
//
// PARAMETERS
// - LOCK_SYNC_STAGES   2      flops on clk_locked_i synchroniser (>=2)
// - POR_HOLD_CYCLES    1024   cycles SoC reset held after lock seen (>=1)
// - TRST_DELAY_CYCLES  16     cycles between soc_rst_n_o and jtag_trst_n_o release (>=1)
// - SW_PULSE_CYCLES    64     warm-reset pulse width in cycles (>=1)
// - DEBOUNCE_CYCLES    65536  stable cycles required on btn_rst_i (BTN_RESET_EN only)
// - CNT_W              20     shared counter width; must hold max of the cycle parameters
//
// PORTS
// - ref_clk        in   1  board reference clock; single clock domain
// - pad_reset      in   1  async reset, active-high (board reset pad)
// - clk_locked_i   in   1  clock-source lock flag, async, synchronised internally
// - sw_rst_req_i   in   1  warm-reset request, level, from SoC GPIO
// - sw_rst_ack_o   out  1  one-cycle ack that the warm reset was accepted
// - btn_rst_i      in   1  extra user reset button, active-high, async (used only with BTN_RESET_EN)
// - soc_rst_n_o    out  1  SoC reset, active-low, drives pad_reset_n
// - jtag_trst_n_o  out  1  JTAG TRST, active-low, drives pad_jtag_trst
// - state_o        out  3  current FSM state encoding, for debug LEDs
//
// BEHAVIOUR
// - Outputs registered. pad_reset high forces the following asynchronously: state=RESET, counter=0, soc_rst_n_o=0, jtag_trst_n_o=0, sw_rst_ack_o=0, state_o=0.
// - FSM states, with state_o encoding:
//   - RESET(0): leave to WAIT_LOCK on the first clock after pad_reset deasserts.
//   - WAIT_LOCK(1): counter=0. Go to HOLD when synced lock=1.
//   - HOLD(2): count POR_HOLD_CYCLES. If synced lock drops, go to WAIT_LOCK and clear the counter. At count==POR_HOLD_CYCLES-1, go to REL_SOC.
//   - REL_SOC(3): soc_rst_n_o=1. Count TRST_DELAY_CYCLES, then go to RUN.
//   - RUN(4): both resets deasserted.
//   - SW_RST(5): soc_rst_n_o=0, jtag_trst_n_o stays 1. Count SW_PULSE_CYCLES, then go to RUN.
// - Resets are registered from the next state, so output edges align with state entry:
//   - soc_rst_n_o=1 in REL_SOC and RUN.
//   - jtag_trst_n_o=1 in RUN and SW_RST.
// - Release latency: soc_rst_n_o rises exactly POR_HOLD_CYCLES cycles after synced lock is first seen high. jtag_trst_n_o rises TRST_DELAY_CYCLES cycles after that.
// - Lock loss in REL_SOC, RUN or SW_RST: next cycle go to WAIT_LOCK. Both resets assert together and the counter clears.
// - Warm reset:
//   - In RUN with sw_rst_req_i=1 and armed=1: go to SW_RST, pulse sw_rst_ack_o for the entry cycle, clear armed.
//   - armed is set to 1 in RESET and re-sets on any cycle with sw_rst_req_i=0. A held request therefore fires only once.
//   - sw_rst_req_i outside RUN is ignored and no ack is given. It is not queued.
// - Lock loss has priority over sw_rst_req_i in the same cycle.
// - Counter compares use ==. The counter is never allowed to wrap. Parameter values that overflow CNT_W are an $error at elaboration.
//
// CONFIGURATION
// - Macro PULPISSIMO_RSTSEQ_BTN_RESET_EN controls the btn_rst_i path.
// - With the macro defined:
//   - btn_rst_i passes through a 2-flop synchroniser and a debounce counter. The level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
//   - A debounced rising edge in any state except RESET forces a full cold sequence: go to WAIT_LOCK, assert both resets.
//   - This has priority over lock loss and over sw_rst_req_i.
// - Without the macro: btn_rst_i is unconnected internally, no debounce logic is built, and the remaining behaviour is identical.
//
// TESTING
// Benches use POR_HOLD_CYCLES=8, TRST_DELAY_CYCLES=4, SW_PULSE_CYCLES=5, DEBOUNCE_CYCLES=16.
// - Cold start: release pad_reset with lock=1 -> soc_rst_n_o rises 8 cycles after synced lock=1; trst_n rises 4 cycles later; state_o steps 0,1,2,3,4.
// - Lock glitch: drop lock for 1 cycle at HOLD count 5 -> back to WAIT_LOCK; full 8-cycle hold restarts after lock returns.
// - Warm reset: in RUN hold sw_rst_req_i=1 for 20 cycles -> one ack pulse; soc_rst_n_o low for exactly 5 cycles; trst_n stays 1; no second pulse until req drops and rises again.
// - Lock loss and sw_rst_req_i rise on the same cycle in RUN -> WAIT_LOCK, no ack, both resets low next cycle.
// - Assert pad_reset mid SW_RST (count 2) -> all outputs 0 asynchronously, before the next ref_clk edge.
// - With BTN_RESET_EN: 10-cycle btn pulse -> ignored; 20-cycle btn pulse in RUN -> cold sequence (both resets low, state_o=1). Without the macro, the same stimulus has no effect.

Source files
------------

// File: rtl/pulpissimo_reset_sequencer.sv
// Sequenced SoC / JTAG-TRST reset generator for the PULPissimo FPGA top, ref_clk domain.
// Optional debounced user reset button: define PULPISSIMO_RSTSEQ_BTN_RESET_EN.
module pulpissimo_reset_sequencer #(
    parameter int unsigned LOCK_SYNC_STAGES  = 2,
    parameter int unsigned POR_HOLD_CYCLES   = 1024,
    parameter int unsigned TRST_DELAY_CYCLES = 16,
    parameter int unsigned SW_PULSE_CYCLES   = 64,
    parameter int unsigned DEBOUNCE_CYCLES   = 65536,
    parameter int unsigned CNT_W             = 20
) (
    input  logic       ref_clk,
    input  logic       pad_reset,
    input  logic       clk_locked_i,
    input  logic       sw_rst_req_i,
    output logic       sw_rst_ack_o,
    input  logic       btn_rst_i,
    output logic       soc_rst_n_o,
    output logic       jtag_trst_n_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_REL_SOC   = 3'd3,
        ST_RUN       = 3'd4,
        ST_SW_RST    = 3'd5
    } state_e;

    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    if (LOCK_SYNC_STAGES < 2) begin : g_err_sync
        $error("LOCK_SYNC_STAGES must be at least 2");
    end
    if (POR_HOLD_CYCLES < 1 || longint'(POR_HOLD_CYCLES) > CNT_RANGE) begin : g_err_por
        $error("POR_HOLD_CYCLES out of range for CNT_W");
    end
    if (TRST_DELAY_CYCLES < 1 || longint'(TRST_DELAY_CYCLES) > CNT_RANGE) begin : g_err_trst
        $error("TRST_DELAY_CYCLES out of range for CNT_W");
    end
    if (SW_PULSE_CYCLES < 1 || longint'(SW_PULSE_CYCLES) > CNT_RANGE) begin : g_err_sw
        $error("SW_PULSE_CYCLES out of range for CNT_W");
    end
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_RANGE) begin : g_err_db
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(POR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRST_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        armed_q, armed_d;
    logic                        soc_rst_n_q, soc_rst_n_d;
    logic                        trst_n_q, trst_n_d;
    logic                        ack_q, ack_d;
    logic [LOCK_SYNC_STAGES-1:0] lock_sync_q;
    logic                        lock_ok;
    logic                        btn_rise;

    assign lock_ok = lock_sync_q[LOCK_SYNC_STAGES-1];

`ifdef PULPISSIMO_RSTSEQ_BTN_RESET_EN
    logic [1:0]       btn_sync_q;
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

    // The debounced level flips only after DEBOUNCE_CYCLES consecutive opposite samples.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_sync_q[1] != btn_db_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            btn_sync_q <= '0;
            btn_db_q   <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], btn_rst_i};
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign btn_rise = btn_db_d & ~btn_db_q;
`else
    logic unused_btn;
    assign unused_btn = btn_rst_i;
    assign btn_rise   = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments only; all decode lives in always_comb.
    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            soc_rst_n_q <= 1'b0;
            trst_n_q    <= 1'b0;
            ack_q       <= 1'b0;
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            soc_rst_n_q <= soc_rst_n_d;
            trst_n_q    <= trst_n_d;
            ack_q       <= ack_d;
            lock_sync_q <= {lock_sync_q[LOCK_SYNC_STAGES-2:0], clk_locked_i};
        end
    end

    // Priority: button cold reset, then lock loss, then count expiry / warm request.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_RESET:     state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_ok) state_d = ST_HOLD;
            ST_HOLD: begin
                if (!lock_ok)                state_d = ST_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = ST_REL_SOC;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_REL_SOC: begin
                if (!lock_ok)                state_d = ST_WAIT_LOCK;
                else if (cnt_q == TRST_LAST) state_d = ST_RUN;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (!lock_ok)                     state_d = ST_WAIT_LOCK;
                else if (sw_rst_req_i && armed_q) state_d = ST_SW_RST;
            end
            ST_SW_RST: begin
                if (!lock_ok)              state_d = ST_WAIT_LOCK;
                else if (cnt_q == SW_LAST) state_d = ST_RUN;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            default:      state_d = ST_RESET;
        endcase
        if (btn_rise && state_q != ST_RESET) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    always_comb begin
        armed_d = armed_q;
        if (state_q == ST_RESET || !sw_rst_req_i) begin
            armed_d = 1'b1;
        end else if (state_q == ST_RUN && state_d == ST_SW_RST) begin
            armed_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so their edges coincide with state entry.
    always_comb begin
        soc_rst_n_d = (state_d == ST_REL_SOC) || (state_d == ST_RUN);
        trst_n_d    = (state_d == ST_RUN) || (state_d == ST_SW_RST);
        ack_d       = (state_q == ST_RUN) && (state_d == ST_SW_RST);
    end

    assign soc_rst_n_o   = soc_rst_n_q;
    assign jtag_trst_n_o = trst_n_q;
    assign sw_rst_ack_o  = ack_q;
    assign state_o       = state_q;

endmodule
